// File: rtl/bht_port_scheduler_pkg.sv
// Shared definitions for the BHT port scheduler.
//   IDX_W_DEF     default BHT index width (table has 2^IDX_W entries)
//   CNT_WEAK_NT   value written to every entry by the post-reset sweep
//   state_t       scheduler FSM encoding
//   pc_word_index word index of a PC; callers keep the low IDX_W bits
package bht_port_scheduler_pkg;

    localparam int         IDX_W_DEF   = 8;
    localparam logic [1:0] CNT_WEAK_NT = 2'b01;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_RD   = 2'd2,
        ST_WR   = 2'd3
    } state_t;

    // Instructions are word aligned, so the two LSBs carry no information.
    function automatic logic [63:0] pc_word_index(input logic [63:0] pc);
        return pc >> 2;
    endfunction

endpackage

// File: rtl/bht_port_scheduler_train_fifo.sv
// Synchronous FIFO holding pending training events {index, taken}.
//   clk, rst      clock, asynchronous active-low reset
//   push, din     write an entry (ignored when full)
//   pop           drop the head entry (ignored when empty)
//   dout          head entry, combinational from the storage
//   full, empty   occupancy flags
//   count         number of valid entries
module train_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [W-1:0]     slot [DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = slot[rd_ptr_reg];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [W-1:0] entry_reg;
            always_ff @(posedge clk) begin
                if (push_ok && wr_ptr_reg == PTR_W'(gi)) begin
                    entry_reg <= din;
                end
            end
            assign slot[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/bht_port_scheduler.sv
// Arbiter/sequencer for the single-port branch history table.
//   clk, rst                     clock, asynchronous active-low reset
//   rdy                          global ready; 0 freezes all state, port idle
//   lkp_req/lkp_pc/lkp_gnt       fetch lookup request and same-cycle grant
//   lkp_valid/lkp_taken          lookup result one cycle after the grant
//   train_valid/taken/pc/ready   commit-time training events into the FIFO
//   bht_en/we/addr/wdata/rdata   BHT RAM port (read data one cycle after read)
//   init_done                    post-reset sweep to weakly-not-taken finished
module bht_port_scheduler
    import bht_port_scheduler_pkg::*;
#(
    parameter int IDX_W      = IDX_W_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              lkp_req,
    input  logic [ADDR_W-1:0] lkp_pc,
    output logic              lkp_gnt,
    output logic              lkp_valid,
    output logic              lkp_taken,
    input  logic              train_valid,
    input  logic              train_taken,
    input  logic [ADDR_W-1:0] train_pc,
    output logic              train_ready,
    output logic              bht_en,
    output logic              bht_we,
    output logic [IDX_W-1:0]  bht_addr,
    output logic [1:0]        bht_wdata,
    input  logic [1:0]        bht_rdata,
    output logic              init_done
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t           state_reg;
    logic [IDX_W-1:0] sweep_reg;
    logic             init_done_reg;
    logic [1:0]       cnt_reg;
    logic             lkp_valid_reg;
    logic             train_ready_reg;

    logic [IDX_W-1:0] lkp_idx;
    logic [IDX_W-1:0] train_idx;
    logic [IDX_W:0]   fifo_dout;
    logic [IDX_W-1:0] head_idx;
    logic             head_taken;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] fifo_count_next;
    logic             fifo_push;
    logic             fifo_pop;
    logic             sweep_last;
    logic             init_done_next;
    logic             train_ready_next;
    logic [1:0]       cnt_upd;

    logic             port_en;
    logic             port_we;
    logic [IDX_W-1:0] port_addr;
    logic [1:0]       port_wdata;

    assign lkp_idx    = IDX_W'(pc_word_index(64'(lkp_pc)));
    assign train_idx  = IDX_W'(pc_word_index(64'(train_pc)));
    assign head_idx   = fifo_dout[IDX_W:1];
    assign head_taken = fifo_dout[0];

    // Lookups own the port whenever the table is initialised.
    assign lkp_gnt    = lkp_req & rdy & init_done_reg;
    assign fifo_push  = train_valid & train_ready_reg & ~fifo_full & rdy;

    train_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (IDX_W + 1)
    ) u_train_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   ({train_idx, train_taken}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // 2-bit saturating counter step, no wrap in either direction.
    always_comb begin
        cnt_upd = cnt_reg;
        if (head_taken) begin
            if (cnt_reg != 2'b11) cnt_upd = cnt_reg + 2'd1;
        end else begin
            if (cnt_reg != 2'b00) cnt_upd = cnt_reg - 2'd1;
        end
    end

    // Port mux: granted lookup first, otherwise whatever the FSM needs.
    always_comb begin
        port_en    = 1'b0;
        port_we    = 1'b0;
        port_addr  = sweep_reg;
        port_wdata = 2'b00;
        fifo_pop   = 1'b0;
        if (lkp_gnt) begin
            port_en   = 1'b1;
            port_addr = lkp_idx;
        end else if (rdy) begin
            case (state_reg)
                ST_INIT: begin
                    port_en    = 1'b1;
                    port_we    = 1'b1;
                    port_addr  = sweep_reg;
                    port_wdata = CNT_WEAK_NT;
                end
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        port_en   = 1'b1;
                        port_addr = head_idx;
                    end
                end
                ST_WR: begin
                    port_en    = 1'b1;
                    port_we    = 1'b1;
                    port_addr  = head_idx;
                    port_wdata = cnt_upd;
                    fifo_pop   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // The RAM must see no enable while reset is held, even though the FSM
    // already sits in INIT pointing at entry 0.
    assign bht_en    = port_en & rst;
    assign bht_we    = port_we & rst;
    assign bht_addr  = port_addr;
    assign bht_wdata = rst ? port_wdata : 2'b00;

    assign sweep_last       = (sweep_reg == {IDX_W{1'b1}});
    assign init_done_next   = init_done_reg | (state_reg == ST_INIT && sweep_last);
    assign fifo_count_next  = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);
    // Readiness looks at next-cycle occupancy, so a full FIFO refuses a push
    // even in the cycle a pop frees a slot.
    assign train_ready_next = init_done_next && (fifo_count_next != CNT_W'(FIFO_DEPTH));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= ST_INIT;
            sweep_reg       <= '0;
            init_done_reg   <= 1'b0;
            cnt_reg         <= 2'b00;
            lkp_valid_reg   <= 1'b0;
            train_ready_reg <= 1'b0;
        end else if (rdy) begin
            lkp_valid_reg   <= lkp_gnt;
            train_ready_reg <= train_ready_next;
            case (state_reg)
                ST_INIT: begin
                    sweep_reg <= sweep_reg + IDX_W'(1);
                    if (sweep_last) begin
                        state_reg     <= ST_IDLE;
                        init_done_reg <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (!lkp_gnt && !fifo_empty) state_reg <= ST_RD;
                end
                ST_RD: begin
                    cnt_reg   <= bht_rdata;
                    state_reg <= ST_WR;
                end
                ST_WR: begin
                    if (!lkp_gnt) state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_INIT;
            endcase
        end
    end

    assign lkp_valid   = lkp_valid_reg;
    assign lkp_taken   = lkp_valid_reg & bht_rdata[1];
    assign train_ready = train_ready_reg;
    assign init_done   = init_done_reg;

endmodule

// File: tb/tb_bht_port_scheduler.sv
// Self-checking bench for bht_port_scheduler with a behavioural BHT RAM,
// a reference counter table and scoreboards for writes and lookups.
module tb_bht_port_scheduler;

    localparam int IDX_W  = 8;
    localparam int ADDR_W = 32;
    localparam int NENT   = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic              rdy;
    logic              lkp_req;
    logic [ADDR_W-1:0] lkp_pc;
    logic              lkp_gnt;
    logic              lkp_valid;
    logic              lkp_taken;
    logic              train_valid;
    logic              train_taken;
    logic [ADDR_W-1:0] train_pc;
    logic              train_ready;
    logic              bht_en;
    logic              bht_we;
    logic [IDX_W-1:0]  bht_addr;
    logic [1:0]        bht_wdata;
    logic [1:0]        bht_rdata;
    logic              init_done;

    always #5 clk = ~clk;

    bht_port_scheduler #(
        .IDX_W      (IDX_W),
        .FIFO_DEPTH (4),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .lkp_req     (lkp_req),
        .lkp_pc      (lkp_pc),
        .lkp_gnt     (lkp_gnt),
        .lkp_valid   (lkp_valid),
        .lkp_taken   (lkp_taken),
        .train_valid (train_valid),
        .train_taken (train_taken),
        .train_pc    (train_pc),
        .train_ready (train_ready),
        .bht_en      (bht_en),
        .bht_we      (bht_we),
        .bht_addr    (bht_addr),
        .bht_wdata   (bht_wdata),
        .bht_rdata   (bht_rdata),
        .init_done   (init_done)
    );

    // BHT RAM model: registered read that holds its output when not read.
    logic [1:0] mem [NENT];
    logic [1:0] rdata_q = 2'b00;
    always @(posedge clk) begin
        if (bht_en) begin
            if (bht_we) mem[bht_addr] <= bht_wdata;
            else        rdata_q       <= mem[bht_addr];
        end
    end
    assign bht_rdata = rdata_q;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [1:0] ref_cnt [NENT];
    logic [9:0] exp_wr [$];
    logic       exp_lkp [$];
    int         sweep_exp = 0;
    int         wr_seen = 0;
    int         cyc = 0;
    int         last_wr_cyc = 0;
    int         prev_wr_cyc = 0;
    logic [1:0] last_wr_data = 2'b00;

    function automatic logic [7:0] idx_of(input logic [31:0] pc);
        return pc[9:2];
    endfunction

    // Monitor: checks sweep writes, training writes and lookup results.
    always @(negedge clk) begin
        logic [9:0] e_wr;
        logic       e_lk;
        cyc = cyc + 1;
        if (!rst) begin
            sweep_exp = 0;
        end else begin
            if (lkp_valid) begin
                n_checks++;
                if (exp_lkp.size() == 0) begin
                    $display("FAIL lkp_unexpected: lkp_valid=1 with no outstanding grant");
                end else begin
                    e_lk = exp_lkp.pop_front();
                    if (lkp_taken !== e_lk)
                        $display("FAIL lkp_result: lkp_taken=%0b expected %0b", lkp_taken, e_lk);
                    else n_pass++;
                end
            end
            if (lkp_gnt) begin
                n_checks++;
                if ({bht_en, bht_we, bht_addr} !== {1'b1, 1'b0, idx_of(lkp_pc)})
                    $display("FAIL lkp_port: en=%0b we=%0b addr=%0h expected 1 0 %0h",
                             bht_en, bht_we, bht_addr, idx_of(lkp_pc));
                else n_pass++;
                exp_lkp.push_back(ref_cnt[idx_of(lkp_pc)][1]);
            end else if (bht_en && bht_we) begin
                n_checks++;
                if (!init_done) begin
                    if ({bht_addr, bht_wdata} !== {sweep_exp[7:0], 2'b01})
                        $display("FAIL sweep_write: addr=%0h data=%0b expected addr=%0h data=01",
                                 bht_addr, bht_wdata, sweep_exp[7:0]);
                    else n_pass++;
                    sweep_exp++;
                end else if (exp_wr.size() == 0) begin
                    $display("FAIL wr_unexpected: addr=%0h data=%0b with no pending update",
                             bht_addr, bht_wdata);
                end else begin
                    e_wr = exp_wr.pop_front();
                    if ({bht_addr, bht_wdata} !== e_wr)
                        $display("FAIL train_write: addr=%0h data=%0b expected addr=%0h data=%0b",
                                 bht_addr, bht_wdata, e_wr[9:2], e_wr[1:0]);
                    else n_pass++;
                    wr_seen++;
                    last_wr_data = bht_wdata;
                    prev_wr_cyc  = last_wr_cyc;
                    last_wr_cyc  = cyc;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_model();
        for (int i = 0; i < NENT; i++) ref_cnt[i] = 2'b01;
        exp_wr.delete();
        exp_lkp.delete();
    endtask

    // Offer one training event and hold it until accepted.
    task automatic send_train(input logic [31:0] pc, input logic tk);
        logic       acc;
        logic [7:0] ix;
        logic [1:0] c;
        train_pc    = pc;
        train_taken = tk;
        train_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            acc = train_ready && rdy;
            tick();
            if (acc) begin
                ix = idx_of(pc);
                c  = ref_cnt[ix];
                if (tk) c = (c == 2'b11) ? 2'b11 : c + 2'd1;
                else    c = (c == 2'b00) ? 2'b00 : c - 2'd1;
                ref_cnt[ix] = c;
                exp_wr.push_back({ix, c});
                train_valid = 1'b0;
                return;
            end
        end
        n_checks++;
        $display("FAIL train_accept_timeout: pc=%0h never accepted", pc);
        train_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (exp_wr.size() == 0) begin
                done = 1;
                break;
            end
        end
        if (!done) begin
            n_checks++;
            $display("FAIL drain_timeout: %0d updates still pending", exp_wr.size());
        end
        repeat (3) tick();
    endtask

    task automatic do_lookup(input logic [31:0] pc, input logic exp_taken);
        lkp_pc  = pc;
        lkp_req = 1'b1;
        @(negedge clk);
        n_checks++;
        if (lkp_gnt !== 1'b1) $display("FAIL lookup_gnt: lkp_gnt=%0b expected 1", lkp_gnt);
        else n_pass++;
        tick();
        lkp_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({lkp_valid, lkp_taken} !== {1'b1, exp_taken})
            $display("FAIL lookup_result pc=%0h: valid=%0b taken=%0b expected 1 %0b",
                     pc, lkp_valid, lkp_taken, exp_taken);
        else n_pass++;
        tick();
    endtask

    task automatic wait_init(input string tag);
        int n = -1;
        bit early = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (init_done) begin
                n = i;
                break;
            end
            if (lkp_gnt) early = 1;
        end
        n_checks++;
        if (n != 256) $display("FAIL %s_latency: init_done after %0d cycles expected 256", tag, n);
        else n_pass++;
        n_checks++;
        if (early) $display("FAIL %s_early_gnt: lkp_gnt=1 before init_done expected 0", tag);
        else n_pass++;
        n_checks++;
        if (sweep_exp != 256) $display("FAIL %s_sweep_count: %0d writes expected 256", tag, sweep_exp);
        else n_pass++;
        n_checks++;
        if (train_ready !== 1'b1) $display("FAIL %s_ready: train_ready=%0b expected 1", tag, train_ready);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; rdy = 1'b1; lkp_req = 1'b1; lkp_pc = '0;
        train_valid = 1'b0; train_taken = 1'b0; train_pc = '0;
        reset_model();
        repeat (3) tick();
        @(negedge clk);
        n_checks++;
        if ({lkp_gnt, lkp_valid, lkp_taken, train_ready, bht_en, bht_we, bht_addr, bht_wdata, init_done} !== 17'd0)
            $display("FAIL reset_outputs: gnt=%0b val=%0b tk=%0b rdy=%0b en=%0b we=%0b addr=%0h wd=%0b done=%0b expected all 0",
                     lkp_gnt, lkp_valid, lkp_taken, train_ready, bht_en, bht_we, bht_addr, bht_wdata, init_done);
        else n_pass++;
        tick();
    endtask

    task automatic test_init();
        rst = 1'b1;
        wait_init("init");
        lkp_req = 1'b0;
        tick();
    endtask

    task automatic test_train_basic();
        send_train(32'h40, 1'b1);
        @(negedge clk);
        n_checks++;
        if ({bht_en, bht_we, bht_addr} !== {1'b1, 1'b0, 8'h10})
            $display("FAIL basic_read: en=%0b we=%0b addr=%0h expected 1 0 10", bht_en, bht_we, bht_addr);
        else n_pass++;
        tick();
        @(negedge clk);
        n_checks++;
        if (bht_en !== 1'b0) $display("FAIL basic_rd_idle: bht_en=%0b expected 0", bht_en);
        else n_pass++;
        tick();
        @(negedge clk);
        n_checks++;
        if ({bht_en, bht_we, bht_addr, bht_wdata} !== {1'b1, 1'b1, 8'h10, 2'b10})
            $display("FAIL basic_write: en=%0b we=%0b addr=%0h data=%0b expected 1 1 10 10",
                     bht_en, bht_we, bht_addr, bht_wdata);
        else n_pass++;
        wait_drain();
        do_lookup(32'h40, 1'b1);
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 4; i++) send_train(32'h80, 1'b1);
        wait_drain();
        n_checks++;
        if (last_wr_data !== 2'b11) $display("FAIL sat_high: counter=%0b expected 11", last_wr_data);
        else n_pass++;
        n_checks++;
        if (last_wr_cyc - prev_wr_cyc != 3)
            $display("FAIL back_to_back_spacing: %0d cycles expected 3", last_wr_cyc - prev_wr_cyc);
        else n_pass++;
        do_lookup(32'h80, 1'b1);
        for (int i = 0; i < 5; i++) send_train(32'h80, 1'b0);
        wait_drain();
        n_checks++;
        if (last_wr_data !== 2'b00) $display("FAIL sat_low: counter=%0b expected 00", last_wr_data);
        else n_pass++;
        do_lookup(32'h80, 1'b0);
    endtask

    task automatic test_wr_stall();
        send_train(32'hC0, 1'b1);
        tick();
        tick();
        lkp_pc  = 32'h40;
        lkp_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({lkp_gnt, bht_we} !== 2'b10)
                $display("FAIL stall_gnt[%0d]: gnt=%0b we=%0b expected 1 0", i, lkp_gnt, bht_we);
            else n_pass++;
            if (i > 0) begin
                n_checks++;
                if (lkp_valid !== 1'b1) $display("FAIL stall_valid[%0d]: lkp_valid=%0b expected 1", i, lkp_valid);
                else n_pass++;
            end
            tick();
        end
        lkp_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bht_en, bht_we, bht_addr, bht_wdata, lkp_valid} !== {1'b1, 1'b1, 8'h30, 2'b10, 1'b1})
            $display("FAIL stall_write: en=%0b we=%0b addr=%0h data=%0b valid=%0b expected 1 1 30 10 1",
                     bht_en, bht_we, bht_addr, bht_wdata, lkp_valid);
        else n_pass++;
        tick();
        @(negedge clk);
        n_checks++;
        if (lkp_valid !== 1'b0) $display("FAIL stall_valid_end: lkp_valid=%0b expected 0", lkp_valid);
        else n_pass++;
        wait_drain();
    endtask

    task automatic test_fifo_full();
        int wr_before;
        lkp_pc  = 32'h40;
        lkp_req = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) send_train(32'h100, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (train_ready !== 1'b0) $display("FAIL full_ready[%0d]: train_ready=%0b expected 0", i, train_ready);
            else n_pass++;
            tick();
        end
        lkp_req   = 1'b0;
        wr_before = wr_seen;
        send_train(32'h100, 1'b1);
        n_checks++;
        if (wr_seen - wr_before != 1)
            $display("FAIL fifth_after_pop: %0d pops before accept expected 1", wr_seen - wr_before);
        else n_pass++;
        wait_drain();
    endtask

    task automatic test_rdy_freeze();
        send_train(32'h140, 1'b1);
        tick();
        rdy     = 1'b0;
        lkp_pc  = 32'h40;
        lkp_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if ({lkp_gnt, bht_en, bht_we, lkp_valid, train_ready, init_done} !== 6'b000011)
                $display("FAIL freeze[%0d]: gnt=%0b en=%0b we=%0b val=%0b rdy=%0b done=%0b expected 0 0 0 0 1 1",
                         i, lkp_gnt, bht_en, bht_we, lkp_valid, train_ready, init_done);
            else n_pass++;
            tick();
        end
        rdy     = 1'b1;
        lkp_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bht_en !== 1'b0) $display("FAIL resume_rd: bht_en=%0b expected 0", bht_en);
        else n_pass++;
        tick();
        @(negedge clk);
        n_checks++;
        if ({bht_en, bht_we, bht_addr, bht_wdata} !== {1'b1, 1'b1, 8'h50, 2'b10})
            $display("FAIL resume_write: en=%0b we=%0b addr=%0h data=%0b expected 1 1 50 10",
                     bht_en, bht_we, bht_addr, bht_wdata);
        else n_pass++;
        wait_drain();
        do_lookup(32'h140, 1'b1);
    endtask

    task automatic test_reset_mid();
        send_train(32'h40, 1'b1);
        tick();
        rst = 1'b0;
        reset_model();
        @(negedge clk);
        n_checks++;
        if ({lkp_valid, train_ready, bht_en, bht_we, bht_wdata, init_done} !== 7'd0)
            $display("FAIL midreset_outputs: val=%0b rdy=%0b en=%0b we=%0b wd=%0b done=%0b expected all 0",
                     lkp_valid, train_ready, bht_en, bht_we, bht_wdata, init_done);
        else n_pass++;
        tick();
        rst = 1'b1;
        wait_init("reinit");
        repeat (6) tick();
        do_lookup(32'h40, 1'b0);
    endtask

    initial begin
        test_reset();
        test_init();
        test_train_basic();
        test_saturate();
        test_wr_stall();
        test_fifo_full();
        test_rdy_freeze();
        test_reset_mid();
        n_checks++;
        if (exp_wr.size() != 0 || exp_lkp.size() != 0)
            $display("FAIL scoreboard_leftover: %0d writes %0d lookups pending expected 0 0",
                     exp_wr.size(), exp_lkp.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
